// File: rtl/rca_seq_adder.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_adder
// Description : Multi-cycle add/subtract unit. One CHUNK-bit slice is summed
//               per cycle through a CHUNK-bit ripple-carry stage, with the
//               carry held in a register between slices. A WIDTH-bit result
//               takes WIDTH/CHUNK cycles, so the critical path scales with
//               CHUNK rather than WIDTH. Valid/ready handshakes on both sides.
//
// Ports       : clk        clock, rising edge
//               rst_n      asynchronous active-low reset
//               in_valid   operands valid          (in)
//               in_ready   operation accepted      (out, IDLE only)
//               a, b       WIDTH-bit operands      (in)
//               cin        carry-in / borrow-in    (in)
//               sub        0: a+b+cin, 1: a-b-cin  (in)
//               out_valid  result valid            (out, DONE only)
//               out_ready  result consumed         (in)
//               sum        WIDTH-bit result        (out)
//               cout       MSB carry-out (sub: 1 = no borrow)   (out)
//               ovf        two's-complement overflow            (out)
//
// Revision    : 1.0 - initial release
// ============================================================================
module rca_seq_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_NCHUNK = WIDTH / CHUNK;
    localparam int c_CW     = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam int c_IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;       // already inverted for subtract
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [c_IW-1:0]  w_base;
    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK:0]   w_add;
    logic             w_last;

    // Bit offset of the slice being worked on this cycle.
    assign w_base    = c_IW'(r_cnt * CHUNK);
    assign w_a_slice = r_a[w_base +: CHUNK];
    assign w_b_slice = r_b[w_base +: CHUNK];

    // CHUNK-bit ripple stage; w_add[CHUNK] is the carry into the next slice.
    assign w_add  = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{CHUNK{1'b0}}, r_carry};
    assign w_last = (r_cnt == c_CW'(c_NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1, so the borrow-in becomes
                        // an inverted carry-in.
                        r_a        <= a;
                        r_b        <= sub ? ~b : b;
                        r_carry    <= cin ^ sub;
                        r_sum      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_S_RUN;
                    end
                end

                c_S_RUN: begin
                    r_sum[w_base +: CHUNK] <= w_add[CHUNK-1:0];
                    r_carry                <= w_add[CHUNK];
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_cout      <= w_add[CHUNK];
                        // The final slice carries the result sign bit, so the
                        // overflow flag can be resolved on this same edge.
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_add[CHUNK-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= c_S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end

                c_S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= c_S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rca_seq_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_seq_adder
// Description : Self-checking bench for rca_seq_adder. Three instances with
//               CHUNK = 8, 1 and 64 share clock and reset; expected results
//               come from a wide-integer behavioural model via a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_seq_adder;

    localparam int c_WIDTH = 64;
    localparam int c_NU    = 3;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid_v  [c_NU];
    logic        in_ready_v  [c_NU];
    logic [63:0] a_v         [c_NU];
    logic [63:0] b_v         [c_NU];
    logic        cin_v       [c_NU];
    logic        sub_v       [c_NU];
    logic        out_valid_v [c_NU];
    logic        out_ready_v [c_NU];
    logic [63:0] sum_v       [c_NU];
    logic        cout_v      [c_NU];
    logic        ovf_v       [c_NU];

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    // Unit 0: CHUNK=8, unit 1: CHUNK=1, unit 2: CHUNK=64.
    int   lat_v [c_NU] = '{8, 64, 1};

    for (genvar g = 0; g < c_NU; g++) begin : g_dut
        localparam int c_CH = (g == 0) ? 8 : (g == 1) ? 1 : 64;
        rca_seq_adder #(.WIDTH(c_WIDTH), .CHUNK(c_CH)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .a         (a_v[g]),
            .b         (b_v[g]),
            .cin       (cin_v[g]),
            .sub       (sub_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .sum       (sum_v[g]),
            .cout      (cout_v[g]),
            .ovf       (ovf_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wide-integer reference: unsigned 65-bit for carry/borrow, signed
    // 66-bit for overflow (the result fits in 64 bits iff bits 65..63 agree).
    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic c, input logic s);
        exp_t        m;
        logic [64:0] u;
        logic [65:0] r;
        logic [65:0] sx;
        logic [65:0] sy;
        sx = {{2{x[63]}}, x};
        sy = {{2{y[63]}}, y};
        if (!s) begin
            u = {1'b0, x} + {1'b0, y} + 65'(c);
            r = sx + sy + 66'(c);
            m.cout = u[64];
        end else begin
            u = {1'b0, x} - {1'b0, y} - 65'(c);
            r = sx - sy - 66'(c);
            m.cout = ~u[64];          // u[64] set means a borrow occurred
        end
        m.sum = u[63:0];
        m.ovf = !((r[65:63] == 3'b000) || (r[65:63] == 3'b111));
        return m;
    endfunction

    // Issue one operation on unit u, check latency and result, optionally
    // stall the consumer for 'hold' cycles while offering a new operand.
    task automatic do_op(input int u, input logic [63:0] ta, input logic [63:0] tb,
                         input logic tcin, input logic tsub, input int hold);
        exp_t e;
        int   cyc;
        sbq.push_back(model(ta, tb, tcin, tsub));

        cyc = 0;
        while (in_ready_v[u] !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("in_ready_idle", 64'(in_ready_v[u]), 64'd1);

        a_v[u] = ta; b_v[u] = tb; cin_v[u] = tcin; sub_v[u] = tsub;
        in_valid_v[u] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[u] = 1'b0;
        check("in_ready_run", 64'(in_ready_v[u]), 64'd0);

        cyc = 0;
        while (out_valid_v[u] !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("latency", 64'(cyc), 64'(lat_v[u]));

        e = sbq.pop_front();
        check("sum",  sum_v[u],          e.sum);
        check("cout", 64'(cout_v[u]),    64'(e.cout));
        check("ovf",  64'(ovf_v[u]),     64'(e.ovf));

        if (hold > 0) begin
            a_v[u] = ~ta;
            in_valid_v[u] = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_out_valid", 64'(out_valid_v[u]), 64'd1);
                check("hold_in_ready",  64'(in_ready_v[u]),  64'd0);
                check("hold_sum",       sum_v[u],            e.sum);
                check("hold_cout",      64'(cout_v[u]),      64'(e.cout));
                check("hold_ovf",       64'(ovf_v[u]),       64'(e.ovf));
            end
            in_valid_v[u] = 1'b0;
        end

        out_ready_v[u] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[u] = 1'b0;
        check("drain_out_valid", 64'(out_valid_v[u]), 64'd0);
        check("drain_in_ready",  64'(in_ready_v[u]),  64'd1);
        check("drain_sum_kept",  sum_v[u],            e.sum);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        rst_n = 1'b0;
        for (int i = 0; i < c_NU; i++) begin
            in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0;
            a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0; sub_v[i] = 1'b0;
        end

        // Reset state
        #2;
        check("rst_sum",       sum_v[0],              64'd0);
        check("rst_out_valid", 64'(out_valid_v[0]),   64'd0);
        check("rst_cout",      64'(cout_v[0]),        64'd0);
        check("rst_ovf",       64'(ovf_v[0]),         64'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready",  64'(in_ready_v[0]),    64'd1);

        // Directed cases on every chunk size
        for (int u = 0; u < c_NU; u++) begin
            do_op(u, 64'd10, 64'd35, 1'b0, 1'b0, 0);
            do_op(u, 64'd23, 64'd132, 1'b1, 1'b0, 0);
            do_op(u, 64'd6223372036854775808, 64'd38701384792384, 1'b1, 1'b0, 0);
            do_op(u, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 0);
            do_op(u, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
        end

        // Subtract
        do_op(0, 64'd100, 64'd35, 1'b0, 1'b1, 0);
        do_op(0, 64'd35, 64'd100, 1'b0, 1'b1, 0);
        do_op(0, 64'd100, 64'd35, 1'b1, 1'b1, 0);

        // Consumer back-pressure
        do_op(0, 64'd10, 64'd35, 1'b0, 1'b0, 5);

        // Reset in the middle of RUN; previous op left cout=1 behind
        do_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 0);
        a_v[0] = 64'h0123_4567_89AB_CDEF; b_v[0] = 64'h1111_1111_1111_1111;
        cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("abort_sum",       sum_v[0],            64'd0);
        check("abort_cout",      64'(cout_v[0]),      64'd0);
        check("abort_ovf",       64'(ovf_v[0]),       64'd0);
        check("abort_out_valid", 64'(out_valid_v[0]), 64'd0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready",  64'(in_ready_v[0]),  64'd1);
        do_op(0, 64'd10, 64'd35, 1'b0, 1'b0, 0);

        // Random operations against the model
        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 17 == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            do_op(i % c_NU, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
